// File: rtl/instr_register_pkg.sv
// Shared types for the pipelined instruction register.
//   opcode_t      : ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
//   operand_t     : signed operand, PKG_OPERAND_W bits
//   result_t      : signed result, 2*PKG_OPERAND_W bits
//   instruction_t : {opc, op_a, op_b, result, err} stored per entry
// The module parameters of instr_register_pipe default to the widths held
// here; overriding them requires changing these localparams to match.
package instr_register_pkg;

    localparam int PKG_OPERAND_W = 32;
    localparam int PKG_DEPTH     = 32;
    localparam int PKG_ADDR_W    = $clog2(PKG_DEPTH);
    localparam int PKG_RESULT_W  = 2 * PKG_OPERAND_W;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [PKG_OPERAND_W-1:0] operand_t;
    typedef logic signed [PKG_RESULT_W-1:0]  result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
        logic     err;
    } instruction_t;

    function automatic logic is_divide(input opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage

// File: rtl/instr_register_pipe_if.sv
// Load/read/writeback bus of the pipelined instruction register.
//   master : instruction source + checker (drives load and read pointer)
//   slave  : instr_register_pipe
// Signals: load_en/load_ready handshake, opcode, operand_a, operand_b,
// write_pointer, read_pointer, instruction_word, wr_valid, wr_addr, wr_count.
interface instr_register_pipe_if;
    import instr_register_pkg::*;

    logic                  load_en;
    logic                  load_ready;
    opcode_t               opcode;
    operand_t              operand_a;
    operand_t              operand_b;
    logic [PKG_ADDR_W-1:0] write_pointer;
    logic [PKG_ADDR_W-1:0] read_pointer;
    instruction_t          instruction_word;
    logic                  wr_valid;
    logic [PKG_ADDR_W-1:0] wr_addr;
    logic [15:0]           wr_count;

    modport master (
        output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  load_ready, instruction_word, wr_valid, wr_addr, wr_count
    );

    modport slave (
        input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output load_ready, instruction_word, wr_valid, wr_addr, wr_count
    );

endinterface

// File: rtl/instr_divider.sv
// Iterative signed restoring divider, one quotient bit per clock.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : load operands (ignored while busy)
//   dividend, divisor   : signed W-bit operands, sampled on start
//   busy                : iteration in progress
//   done                : combinational pulse in the cycle whose closing edge
//                         completes the division (same cycle as start on /0)
//   quotient, remainder : signed 2W-bit results, valid with done
//   div_by_zero         : valid with done; quotient 0, remainder = dividend
// Quotient truncates toward zero, remainder takes the dividend's sign.
module instr_divider #(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic signed [W-1:0]   dividend,
    input  logic signed [W-1:0]   divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic signed [2*W-1:0] quotient,
    output logic signed [2*W-1:0] remainder
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     q_r;
    logic [W-1:0]     rem_r;
    logic [W-1:0]     dvsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic [W:0]       rem_sh;
    logic [W:0]       trial;
    logic [W-1:0]     q_nx;
    logic [W-1:0]     rem_nx;
    logic [2*W-1:0]   q_ext;
    logic [2*W-1:0]   r_ext;
    logic             dz_now;

    // Magnitude as unsigned W bits; the most negative value maps to 2^(W-1).
    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        logic [W-1:0] u;
        u = v;
        return v[W-1] ? (~u + 1'b1) : u;
    endfunction

    assign dz_now = (divisor == '0);

    // One restoring step; the partial remainder never exceeds W bits, so a
    // set MSB in trial means the subtraction went negative.
    always_comb begin
        rem_sh = {rem_r, q_r[W-1]};
        trial  = rem_sh - {1'b0, dvsr_r};
        if (!trial[W]) begin
            rem_nx = trial[W-1:0];
            q_nx   = {q_r[W-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[W-1:0];
            q_nx   = {q_r[W-2:0], 1'b0};
        end
    end

    // The final step is taken combinationally so the result is ready for the
    // writeback edge that also retires the divider.
    assign q_ext       = {{W{1'b0}}, q_nx};
    assign r_ext       = {{W{1'b0}}, rem_nx};
    assign div_by_zero = start && dz_now;
    assign done        = div_by_zero || (busy && (cnt_r == CNT_W'(1)));
    assign quotient    = div_by_zero ? '0
                       : (neg_q_r ? -q_ext : q_ext);
    assign remainder   = div_by_zero ? {{W{dividend[W-1]}}, dividend}
                       : (neg_r_r ? -r_ext : r_ext);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            cnt_r   <= '0;
            q_r     <= '0;
            rem_r   <= '0;
            dvsr_r  <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (start && !busy && !dz_now) begin
            busy    <= 1'b1;
            cnt_r   <= CNT_W'(W);
            q_r     <= mag(dividend);
            dvsr_r  <= mag(divisor);
            rem_r   <= '0;
            neg_q_r <= dividend[W-1] ^ divisor[W-1];
            neg_r_r <= dividend[W-1];
        end else if (busy) begin
            q_r   <= q_nx;
            rem_r <= rem_nx;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_register_pipe.sv
// Pipelined instruction register: DEPTH entries of instruction_t whose
// result is computed by a two-stage execute path.
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : instr_register_pipe_if.slave (load handshake, operands,
//              pointers, combinational read word, writeback report)
// Build option: define INSTR_DIV_EN to instantiate the iterative divider for
// DIV/MOD. Without it DIV/MOD complete in one cycle with result 0, err = 1,
// and load_ready is always high.
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter int OPERAND_W = PKG_OPERAND_W,
    parameter int DEPTH     = PKG_DEPTH
) (
    input logic               clk,
    input logic               reset_n,
    instr_register_pipe_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    instruction_t      mem [DEPTH];

    logic              vld_p1;
    opcode_t           opc_p1;
    operand_t          a_p1;
    operand_t          b_p1;
    logic [ADDR_W-1:0] ptr_p1;

    logic              accept;
    logic              wb_en;
    result_t           wb_result;
    logic              wb_err;

    function automatic result_t sext(input operand_t v);
        return {{OPERAND_W{v[OPERAND_W-1]}}, v};
    endfunction

    // ADD/SUB keep one guard bit before sign extension; MULT is exact in
    // the double-width result.
    function automatic result_t alu(input opcode_t op, input operand_t a, input operand_t b);
        logic signed [PKG_OPERAND_W:0] sum;
        result_t r;
        sum = '0;
        r   = '0;
        case (op)
            PASSA: r = sext(a);
            PASSB: r = sext(b);
            ADD: begin
                sum = {a[PKG_OPERAND_W-1], a} + {b[PKG_OPERAND_W-1], b};
                r   = {{(PKG_OPERAND_W-1){sum[PKG_OPERAND_W]}}, sum};
            end
            SUB: begin
                sum = {a[PKG_OPERAND_W-1], a} - {b[PKG_OPERAND_W-1], b};
                r   = {{(PKG_OPERAND_W-1){sum[PKG_OPERAND_W]}}, sum};
            end
            MULT:    r = sext(a) * sext(b);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

`ifdef INSTR_DIV_EN
    logic    div_start;
    logic    div_busy;
    logic    div_done;
    logic    div_dz;
    result_t div_q;
    result_t div_r;
    logic    alu_wb;

    // S1 keeps the divide instruction until the divider finishes, so its
    // operands and destination are still at hand for the writeback.
    assign div_start = vld_p1 && is_divide(opc_p1) && !div_busy;

    instr_divider #(.W(OPERAND_W)) u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (div_start),
        .dividend    (a_p1),
        .divisor     (b_p1),
        .busy        (div_busy),
        .done        (div_done),
        .div_by_zero (div_dz),
        .quotient    (div_q),
        .remainder   (div_r)
    );

    assign alu_wb         = vld_p1 && !is_divide(opc_p1);
    assign wb_en          = alu_wb || div_done;
    assign wb_result      = alu_wb ? alu(opc_p1, a_p1, b_p1)
                          : ((opc_p1 == MOD) ? div_r : div_q);
    assign wb_err         = div_done && div_dz;
    assign bus.load_ready = !(vld_p1 && is_divide(opc_p1)) && !div_busy;
`else
    assign wb_en          = vld_p1;
    assign wb_result      = alu(opc_p1, a_p1, b_p1);
    assign wb_err         = is_divide(opc_p1);
    assign bus.load_ready = 1'b1;
`endif

    assign accept = bus.load_en && bus.load_ready;

    // ---- S1: capture accepted instruction ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            opc_p1 <= ZERO;
            a_p1   <= '0;
            b_p1   <= '0;
            ptr_p1 <= '0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            opc_p1 <= bus.opcode;
            a_p1   <= bus.operand_a;
            b_p1   <= bus.operand_b;
            ptr_p1 <= bus.write_pointer;
        end else if (wb_en) begin
            vld_p1 <= 1'b0;
        end
    end

    // ---- S2: writeback into the register file ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            bus.wr_valid <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_count <= '0;
        end else begin
            bus.wr_valid <= wb_en;
            if (wb_en) begin
                mem[ptr_p1] <= '{opc: opc_p1, op_a: a_p1, op_b: b_p1,
                                 result: wb_result, err: wb_err};
                bus.wr_addr  <= ptr_p1;
                bus.wr_count <= sat_inc(bus.wr_count);
            end
        end
    end

    assign bus.instruction_word = mem[bus.read_pointer];

endmodule

// File: tb/tb_instr_register_pipe.sv
// Self-checking bench for instr_register_pipe. Expected values follow the
// build: with INSTR_DIV_EN defined the divider results apply, otherwise
// DIV/MOD give result 0 with err set.
module tb_instr_register_pipe;
    import instr_register_pkg::*;

    localparam int W  = PKG_OPERAND_W;
    localparam int IW = $bits(instruction_t);
`ifdef INSTR_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef logic [IW-1:0] wide_t;

    typedef struct {
        opcode_t                opc;
        logic signed [W-1:0]    a;
        logic signed [W-1:0]    b;
        logic [PKG_ADDR_W-1:0]  ptr;
        logic signed [2*W-1:0]  res;
        logic                   err;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    instr_register_pipe_if bus ();

    instr_register_pipe dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   passes    = 0;
    int   exp_count = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic vec_t mk(input opcode_t o, input logic signed [W-1:0] a,
                                input logic signed [W-1:0] b, input int ptr,
                                input logic signed [2*W-1:0] res, input logic err);
        vec_t v;
        v.opc = o; v.a = a; v.b = b; v.ptr = PKG_ADDR_W'(ptr); v.res = res; v.err = err;
        return v;
    endfunction

    task automatic drive(input opcode_t o, input logic signed [W-1:0] a,
                         input logic signed [W-1:0] b, input logic [PKG_ADDR_W-1:0] ptr);
        bus.load_en       = 1'b1;
        bus.opcode        = o;
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.write_pointer = ptr;
    endtask

    task automatic check_entry(input string name, input logic [PKG_ADDR_W-1:0] ptr,
                               input instruction_t exp);
        bus.read_pointer = ptr;
        #1;
        chk(name, bus.instruction_word, exp);
    endtask

    // Apply one vector starting at a negedge; returns at the negedge where
    // the writeback pulse is seen.
    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        bit seen;
        int lat;
        int low;
        int exp_lat;
        int exp_low;
        instruction_t e;
        ok = 1'b0;
        drive(v.opc, v.a, v.b, v.ptr);
        for (int i = 0; i < 200; i++) begin
            if (bus.load_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin timeout($sformatf("vec%0d accept", idx)); bus.load_en = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        bus.load_en = 1'b0;
        lat = 1; low = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.load_ready) low++;
            if (bus.wr_valid) begin seen = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        if (!seen) begin timeout($sformatf("vec%0d writeback", idx)); return; end
        exp_lat = 2; exp_low = 0;
        if (DIV_EN && is_divide(v.opc)) begin
            exp_low = (v.b == 0) ? 1 : W + 1;
            exp_lat = (v.b == 0) ? 2 : W + 2;
        end
        exp_count++;
        chk($sformatf("vec%0d latency", idx), wide_t'(lat), wide_t'(exp_lat));
        chk($sformatf("vec%0d ready_low", idx), wide_t'(low), wide_t'(exp_low));
        chk($sformatf("vec%0d wr_addr", idx), wide_t'(bus.wr_addr), wide_t'(v.ptr));
        chk($sformatf("vec%0d wr_count", idx), wide_t'(bus.wr_count), wide_t'(exp_count));
        e = '{opc: v.opc, op_a: v.a, op_b: v.b, result: v.res, err: v.err};
        check_entry($sformatf("vec%0d entry", idx), v.ptr, e);
    endtask

    initial begin
        int k;
        int pulses;
        instruction_t e;

        bus.load_en = 1'b0; bus.opcode = ZERO; bus.operand_a = '0; bus.operand_b = '0;
        bus.write_pointer = '0; bus.read_pointer = '0;

        vecs.push_back(mk(ZERO,  123, 4, 4, 0, 1'b0));
        vecs.push_back(mk(PASSA, -7, 9, 5, -7, 1'b0));
        vecs.push_back(mk(PASSB, 3, 100, 6, 100, 1'b0));
        vecs.push_back(mk(ADD,   32'sh7FFFFFFF, 1, 7, 64'sh0000_0000_8000_0000, 1'b0));
        vecs.push_back(mk(SUB,   32'sh80000000, 1, 8, 64'shFFFF_FFFF_7FFF_FFFF, 1'b0));
        vecs.push_back(mk(MULT,  32'sh80000000, 32'sh80000000, 9, 64'sh4000_0000_0000_0000, 1'b0));
        vecs.push_back(mk(MULT,  32'sh7FFFFFFF, -1, 10, -64'sh7FFF_FFFF, 1'b0));
        vecs.push_back(mk(SUB,   5, 12, 11, -7, 1'b0));
        vecs.push_back(mk(DIV,   -17, 5, 3, DIV_EN ? -3 : 0, !DIV_EN));
        vecs.push_back(mk(MOD,   -17, 5, 12, DIV_EN ? -2 : 0, !DIV_EN));
        vecs.push_back(mk(DIV,   17, -5, 13, DIV_EN ? -3 : 0, !DIV_EN));
        vecs.push_back(mk(MOD,   17, -5, 14, DIV_EN ? 2 : 0, !DIV_EN));
        vecs.push_back(mk(DIV,   9, 0, 15, 0, 1'b1));
        vecs.push_back(mk(MOD,   9, 0, 16, DIV_EN ? 9 : 0, 1'b1));
        vecs.push_back(mk(DIV,   32'sh80000000, -1, 17, DIV_EN ? 64'sh0000_0000_8000_0000 : 0, !DIV_EN));
        vecs.push_back(mk(MOD,   -100, 7, 18, DIV_EN ? -2 : 0, !DIV_EN));
        vecs.push_back(mk(DIV,   20, 4, 19, DIV_EN ? 5 : 0, !DIV_EN));

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst load_ready", wide_t'(bus.load_ready), wide_t'(1));
        chk("rst wr_valid", wide_t'(bus.wr_valid), wide_t'(0));
        chk("rst wr_addr", wide_t'(bus.wr_addr), wide_t'(0));
        chk("rst wr_count", wide_t'(bus.wr_count), wide_t'(0));
        reset_n = 1'b1;
        for (int i = 0; i < PKG_DEPTH; i++) begin
            check_entry($sformatf("rst entry%0d", i), PKG_ADDR_W'(i), '0);
        end
        @(negedge clk);

        // Back-to-back ADD then MULT
        drive(ADD, 5, -3, 1);
        chk("b2b ready1", wide_t'(bus.load_ready), wide_t'(1));
        @(posedge clk);
        @(negedge clk);
        drive(MULT, -4, 7, 2);
        chk("b2b ready2", wide_t'(bus.load_ready), wide_t'(1));
        @(posedge clk);
        @(negedge clk);
        bus.load_en = 1'b0;
        chk("b2b wr_valid1", wide_t'(bus.wr_valid), wide_t'(1));
        chk("b2b wr_addr1", wide_t'(bus.wr_addr), wide_t'(1));
        check_entry("b2b entry1", 1, '{opc: ADD, op_a: 5, op_b: -3, result: 2, err: 1'b0});
        @(negedge clk);
        chk("b2b wr_valid2", wide_t'(bus.wr_valid), wide_t'(1));
        chk("b2b wr_addr2", wide_t'(bus.wr_addr), wide_t'(2));
        check_entry("b2b entry2", 2, '{opc: MULT, op_a: -4, op_b: 7, result: -28, err: 1'b0});
        @(negedge clk);
        chk("b2b wr_valid off", wide_t'(bus.wr_valid), wide_t'(0));
        chk("b2b wr_count", wide_t'(bus.wr_count), wide_t'(2));
        exp_count = 2;

        // Vector table
        foreach (vecs[i]) run_vec(vecs[i], i);
        @(negedge clk);

        // DIV with an ADD queued behind it
        drive(DIV, -17, 5, 20);
        chk("queue ready div", wide_t'(bus.load_ready), wide_t'(1));
        @(posedge clk);
        @(negedge clk);
        drive(ADD, 1, 1, 21);
        k = 0;
        while (!bus.load_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("queue stall cycles", wide_t'(k), wide_t'(DIV_EN ? W + 1 : 0));
        @(posedge clk);
        @(negedge clk);
        bus.load_en = 1'b0;
        @(negedge clk);
        exp_count += 2;
        chk("queue wr_addr", wide_t'(bus.wr_addr), wide_t'(21));
        chk("queue wr_count", wide_t'(bus.wr_count), wide_t'(exp_count));
        check_entry("queue add entry", 21, '{opc: ADD, op_a: 1, op_b: 1, result: 2, err: 1'b0});
        check_entry("queue div entry", 20, '{opc: DIV, op_a: -17, op_b: 5,
                                             result: DIV_EN ? -3 : 0, err: !DIV_EN});
        @(negedge clk);

        // Reset during divider iteration 10
        drive(DIV, 100, 7, 22);
        @(posedge clk);
        @(negedge clk);
        bus.load_en = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid rst load_ready", wide_t'(bus.load_ready), wide_t'(1));
        chk("mid rst wr_valid", wide_t'(bus.wr_valid), wide_t'(0));
        chk("mid rst wr_count", wide_t'(bus.wr_count), wide_t'(0));
        check_entry("mid rst entry1", 1, '0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wr_valid) pulses++;
        end
        chk("mid rst pulses", wide_t'(pulses), wide_t'(0));
        chk("mid rst ready after", wide_t'(bus.load_ready), wide_t'(1));
        chk("mid rst count after", wide_t'(bus.wr_count), wide_t'(0));
        check_entry("mid rst entry22", 22, '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_register_pipe.md
# instr_register_pipe

Parametrised, pipelined successor of the lab instruction register: a DEPTH-entry register file of instruction words whose result field is produced by a two-stage execute path with an iterative signed divider. It sits between the instruction stimulus source and the checker's read port. Its valid/ready load handshake stalls the source while a DIV or MOD is in flight. Each writeback is reported on a pulse output so the checker can track when entries become valid.

## Interface
- OPERAND_W, 32: signed operand width, ≥ 4.
- DEPTH, 32: number of entries, power of two, ≥ 2.
- ADDR_W, $clog2(DEPTH): pointer width (derived, not overridden).
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  source offers an instruction; held with stable data until accepted.
- load_ready  out  1  block can accept; transfer when load_en && load_ready at clk edge.
- opcode  in  opcode_t  ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD.
- operand_a, operand_b  in  OPERAND_W  signed operands.
- write_pointer  in  ADDR_W  destination entry.
- read_pointer  in  ADDR_W  entry driven on instruction_word.
- instruction_word  out  instruction_t  {opc, op_a, op_b, result, err}, combinational read of entry read_pointer.
- wr_valid  out  1  one-cycle pulse after each writeback.
- wr_addr  out  ADDR_W  entry written; valid with wr_valid.
- wr_count  out  16  total writebacks since reset, saturates at 16'hFFFF.

## Operation
- Stage S1: on accept, capture opcode, operands and write_pointer; s1_valid set.
- Stage S2, non-divide ops: combinational compute on S1 contents; entry written on the following edge.
  - ZERO → 0; PASSA/PASSB → sign-extended operand.
  - ADD/SUB → OPERAND_W+1 bits, sign-extended.
  - MULT → full 2·OPERAND_W signed product.
  - Result width RESULT_W = 2·OPERAND_W.
- DIV/MOD: S1 hands operands to the divider and stays occupied until it finishes.
  - Divider is signed restoring, OPERAND_W iterations; quotient truncates toward zero, remainder takes the dividend's sign.
  - Divide by zero: no iteration; DIV → result 0, MOD → sign-extended operand_a, err = 1.
  - err = 0 for every other case.
- load_ready = !(s1_valid && opcode is DIV/MOD) && !div_busy; combinational from registers only.
- Writebacks are strictly in order; at most one per cycle.
- Writing the entry under read_pointer: instruction_word shows the new value in the cycle after the writeback edge.
- Reset, including mid-divide:
  - all entries become {ZERO, 0, 0, 0, 0}; S1 and divider are cleared; in-flight op is discarded with no writeback.
  - Outputs: load_ready = 1, wr_valid = 0, wr_addr = 0, wr_count = 0.

## Timing
- Non-divide op accepted at edge N: entry written at edge N+1, wr_valid high in cycle N+1..N+2, back-to-back accept every cycle.
- DIV/MOD accepted at edge N: load_ready low from edge N; divider loads at N+1; writeback at edge N+1+OPERAND_W; load_ready high after that edge.
- DIV/MOD by zero: writeback at edge N+1; load_ready low for one cycle only.
- wr_count increments at the writeback edge and holds at 16'hFFFF.

## Configuration
- INSTR_DIV_EN defined: iterative divider instantiated; DIV/MOD behave as above.
- INSTR_DIV_EN undefined: no divider; DIV/MOD take the single-cycle path with result 0 and err = 1; load_ready is constantly 1 outside reset.

## Structure
- instr_register_pkg holds opcode_t, operand_t (OPERAND_W), result_t (2·OPERAND_W) and instruction_t with the added err bit.
- Sub-module instr_divider: start/busy/done handshake, signed quotient and remainder, div-by-zero detect.

## Test plan
- Reset, then read all 32 entries → every field 0; load_ready = 1; wr_count = 0.
- Back-to-back ADD 5+(-3) → ptr 1, then MULT (-4)·7 → ptr 2 → results 2 and -28 at edges N+1 and N+2; two wr_valid pulses; wr_count = 2.
- DIV -17/5 → ptr 3 with ADD queued behind it:
  - load_ready low for 33 cycles; result -3 at edge N+33.
  - ADD accepted only after that edge.
  - MOD -17%5 gives -2.
- DIV 9/0 and MOD 9/0 → results 0 and 9, err = 1, load_ready low for one cycle each.
- Assert reset_n at divider iteration 10 → no writeback, target entry 0, load_ready = 1 after release.
- Build without INSTR_DIV_EN → DIV 20/4 gives result 0, err = 1 at edge N+1; load_ready never drops.
